// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the
// multicycle control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int unsigned SRCB_B     = 0;
  localparam int unsigned SRCB_FOUR  = 1;
  localparam int unsigned SRCB_SEXT  = 2;
  localparam int unsigned SRCB_SHIFT = 3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  function automatic logic is_wait_state(
    input state_t s
  );
    return (s == S_FETCH) ||
           (s == S_MEM_RD) ||
           (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts memory wait cycles and
// flags a timeout on the last permitted one.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign timeout = active && !mem_ready &&
                   (cnt == CW'(MEM_TIMEOUT - 1));

  // count stalled cycles; restart whenever no access is pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!active || mem_ready || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit with
// memory handshake, watchdog and illegal-opcode trap.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUSRCB_W   = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int HAS_BNE     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 PCWriteCondInv,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 IRWrite,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic [1:0]           PCSource,
  output logic [1:0]           ALUOp,
  output logic [ALUSRCB_W-1:0] ALUSrcB,
  output logic                 pc_en,
  output logic [3:0]           state,
  output logic                 fault
);

  localparam logic [OPCODE_W-1:0] OPC_R =
    OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OPC_LW =
    OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_SW =
    OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OPC_BEQ =
    OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OPC_BNE =
    OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] OPC_J =
    OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] OPC_ADDI =
    OPCODE_W'(OP_ADDI);

  state_t st;
  state_t nxt;
  logic   in_wait;
  logic   timeout;
  logic   is_r;
  logic   is_mem;
  logic   is_beq;
  logic   is_bne;
  logic   is_br;
  logic   is_j;
  logic   is_i;

  assign in_wait = is_wait_state(st);
  assign is_r    = (opcode == OPC_R);
  assign is_mem  = (opcode == OPC_LW) ||
                   (opcode == OPC_SW);
  assign is_beq  = (opcode == OPC_BEQ);
  assign is_bne  = (HAS_BNE != 0) &&
                   (opcode == OPC_BNE);
  assign is_br   = is_beq || is_bne;
  assign is_j    = (opcode == OPC_J);
  assign is_i    = (opcode == OPC_ADDI);

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .active   (in_wait),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  // next-state selection; mem_ready beats the watchdog
  always_comb begin
    nxt = st;
    unique case (st)
      S_FETCH: begin
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) nxt = S_FAULT;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r:    nxt = S_R_EXEC;
          is_mem:  nxt = S_MEM_ADDR;
          is_br:   nxt = S_BRANCH;
          is_j:    nxt = S_JUMP;
          is_i:    nxt = S_I_EXEC;
          default: nxt = S_FAULT;
        endcase
      end
      S_MEM_ADDR:
        nxt = (opcode == OPC_SW) ? S_MEM_WR
                                 : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)    nxt = S_MEM_WB;
        else if (timeout) nxt = S_FAULT;
      end
      S_MEM_WR: begin
        if (mem_ready)    nxt = S_FETCH;
        else if (timeout) nxt = S_FAULT;
      end
      S_MEM_WB: nxt = S_FETCH;
      S_R_EXEC: nxt = S_R_WB;
      S_R_WB:   nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_I_EXEC: nxt = S_I_WB;
      S_I_WB:   nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
  end

  // state register and sticky fault flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= S_FETCH;
      fault <= 1'b0;
    end else begin
      st    <= nxt;
      fault <= (nxt == S_FAULT);
    end
  end

  // strobe decode from the current state
  always_comb begin
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    PCWriteCondInv = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    MemtoReg       = 1'b0;
    IRWrite        = 1'b0;
    ALUSrcA        = 1'b0;
    RegWrite       = 1'b0;
    RegDst         = 1'b0;
    PCSource       = PCS_ALU;
    ALUOp          = ALU_ADD;
    ALUSrcB        = ALUSRCB_W'(SRCB_B);
    unique case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUSRCB_W'(SRCB_FOUR);
        IRWrite = mem_ready && reset;
        PCWrite = mem_ready && reset;
      end
      S_DECODE:
        ALUSrcB = ALUSRCB_W'(SRCB_SHIFT);
      S_MEM_ADDR, S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_W'(SRCB_SEXT);
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA        = 1'b1;
        ALUOp          = ALU_SUB;
        PCSource       = PCS_ALUOUT;
        PCWriteCond    = is_beq;
        PCWriteCondInv = is_bne;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_I_WB:
        RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign pc_en = PCWrite ||
                 (PCWriteCond && zero) ||
                 (PCWriteCondInv && !zero);

  assign state = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random + directed checks of
// mc_control_fsm against a per-instruction route model.
module tb_mc_control_fsm;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite, PCWriteCond, PCWriteCondInv;
  logic       IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp;
  logic [2:0] ALUSrcB;
  logic       pc_en, fault;
  logic [3:0] state;

  logic       n_pcw, n_pcwc, n_pcwci, n_iord, n_mrd;
  logic       n_mwr, n_m2r, n_irw, n_srca, n_rw, n_rdst;
  logic [1:0] n_pcs, n_aop;
  logic [2:0] n_srcb;
  logic       n_pc_en, n_fault;
  logic [3:0] n_state;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode;
  int zsel;

  wire [19:0] obs_v = {PCWrite, PCWriteCond,
    PCWriteCondInv, IorD, MemRead, MemWrite,
    MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
    PCSource, ALUOp, ALUSrcB, pc_en, fault};

  mc_control_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCWriteCondInv(PCWriteCondInv), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .pc_en(pc_en), .state(state), .fault(fault)
  );

  mc_control_fsm #(.HAS_BNE(0)) dut_nb (
    .clk(clk), .reset(reset), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(n_pcw), .PCWriteCond(n_pcwc),
    .PCWriteCondInv(n_pcwci), .IorD(n_iord),
    .MemRead(n_mrd), .MemWrite(n_mwr),
    .MemtoReg(n_m2r), .IRWrite(n_irw),
    .ALUSrcA(n_srca), .RegWrite(n_rw),
    .RegDst(n_rdst), .PCSource(n_pcs),
    .ALUOp(n_aop), .ALUSrcB(n_srcb),
    .pc_en(n_pc_en), .state(n_state),
    .fault(n_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog no finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // strobe table written straight from the state list
  function automatic logic [19:0] exp_vec(
    input int s, input bit mr, input bit z,
    input logic [5:0] op);
    bit pcw = 0, pcwc = 0, pcwci = 0, iord = 0;
    bit mrd = 0, mwr = 0, m2r = 0, irw = 0;
    bit srca = 0, rw = 0, rdst = 0, flt = 0, pe;
    logic [1:0] pcs = 0, aop = 0;
    logic [2:0] srcb = 0;
    case (s)
      0:  begin mrd = 1; srcb = 1; irw = mr; pcw = mr; end
      1:  srcb = 3;
      2:  begin srca = 1; srcb = 2; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin
        srca = 1; aop = 1; pcs = 1;
        pcwc = (op == 6'd4); pcwci = (op == 6'd5);
      end
      9:  begin pcw = 1; pcs = 2; end
      10: begin srca = 1; srcb = 2; end
      11: rw = 1;
      default: flt = 1;
    endcase
    pe = pcw | (pcwc & z) | (pcwci & ~z);
    return {pcw, pcwc, pcwci, iord, mrd, mwr, m2r,
            irw, srca, rw, rdst, pcs, aop, srcb,
            pe, flt};
  endfunction

  function automatic bit is_mem_st(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  // reset for a cycle, then release just after a rising edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_strobes", obs_v,
          exp_vec(0, 1'b0, zero, opcode));
    @(posedge clk);
    #1;
    check("rst_hold", state, 0);
    check("rst_irw", IRWrite, 0);
    reset = 1'b1;
  endtask

  // walk one instruction's state route cycle by cycle
  task automatic run_instr(input logic [5:0] op,
                           output bit faulted);
    int route[$];
    int k = 0;
    int w = 0;
    int s;
    faulted = 0;
    case (op)
      6'd0:  route = '{0, 1, 6, 7};
      6'd35: route = '{0, 1, 2, 3, 4};
      6'd43: route = '{0, 1, 2, 5};
      6'd4:  route = '{0, 1, 8};
      6'd5:  route = '{0, 1, 8};
      6'd2:  route = '{0, 1, 9};
      6'd8:  route = '{0, 1, 10, 11};
      default: route = '{0, 1, 15};
    endcase
    while (k < route.size()) begin
      s = route[k];
      @(negedge clk);
      opcode = op;
      zero = (zsel == 2) ? 1'($urandom_range(1))
                         : 1'(zsel);
      mem_ready = (rdy_mode == 1) ? 1'b1 :
                  ($urandom_range(3) != 0);
      #1;
      check("state", state, s);
      check("strobes", obs_v,
            exp_vec(s, mem_ready, zero, op));
      if (s == 15) begin
        faulted = 1;
        break;
      end
      if (is_mem_st(s) && !mem_ready) begin
        w++;
        if (w == T) begin
          route = '{15};
          k = 0;
        end
      end else begin
        k++;
        w = 0;
      end
    end
  endtask

  // cycles from FETCH back to FETCH, stalling MEM_RD
  task automatic cpi(input logic [5:0] op,
                     input int stall, input int exp,
                     input string tag);
    int n = 0;
    int sn = 0;
    do begin
      @(negedge clk);
      opcode = op;
      zero = 1'b0;
      mem_ready = !(state == 4'd3 && sn < stall);
      if (!mem_ready) sn++;
      n++;
      @(posedge clk);
      #1;
    end while (state != 4'd0 && state != 4'd15 &&
               n < 40);
    check(tag, n, exp);
  endtask

  initial begin
    bit f;
    logic [5:0] ops [7] = '{6'd0, 6'd35, 6'd43,
                            6'd4, 6'd5, 6'd2, 6'd8};
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'd0;
    zero = 1'b0;
    rdy_mode = 1;
    zsel = 0;
    #1;
    check("init_state", state, 0);
    check("init_memread", MemRead, 1);
    check("init_irw", IRWrite, 0);
    check("init_pcw", PCWrite, 0);
    check("init_fault", fault, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_decode", state, 1);
    do_reset();

    foreach (ops[i]) run_instr(ops[i], f);
    zsel = 1;
    run_instr(6'd4, f);
    run_instr(6'd5, f);
    zsel = 0;
    run_instr(6'd5, f);

    do_reset();
    repeat (2) begin
      @(negedge clk);
      opcode = 6'd5;
      mem_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    check("nb_state", n_state, 15);
    check("nb_fault", n_fault, 1);
    check("bne_state", state, 8);
    do_reset();

    cpi(6'd0, 0, 4, "cpi_r");
    cpi(6'd35, 0, 5, "cpi_lw");
    cpi(6'd43, 0, 4, "cpi_sw");
    cpi(6'd8, 0, 4, "cpi_addi");
    cpi(6'd4, 0, 3, "cpi_beq");
    cpi(6'd5, 0, 3, "cpi_bne");
    cpi(6'd2, 0, 3, "cpi_j");
    cpi(6'd35, 3, 8, "cpi_lw_stall");

    do_reset();
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("to_wait", state, 0);
    end
    @(negedge clk);
    #1;
    check("to_fault_st", state, 15);
    check("to_fault", fault, 1);
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("to_sticky", obs_v,
            exp_vec(15, 1'b1, zero, opcode));
    end
    do_reset();

    run_instr(6'd63, f);
    check("illegal_fault", f, 1);
    do_reset();

    repeat (3) begin
      @(negedge clk);
      opcode = 6'd0;
      mem_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    check("rwb_state", state, 7);
    reset = 1'b0;
    #1;
    check("rwb_rst_state", state, 0);
    check("rwb_rst_rw", RegWrite, 0);
    check("rwb_rst_irw", IRWrite, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    rdy_mode = 0;
    zsel = 2;
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = ($urandom_range(7) == 0)
           ? 6'($urandom)
           : ops[$urandom_range(6)];
      run_instr(op, f);
      if (f) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
